// File: rtl/mult_bist_ctrl.sv
// BIST sequencer for a combinational multiplier: applies exhaustive or LFSR operand
// vectors, checks each product against A*B and records the first failing vector.
module mult_bist_ctrl #(
    parameter int WIDTH         = 2,
    parameter int NUM_VECTORS   = 20,
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [15:0]        seed,
    output logic [WIDTH-1:0]   mult_a,
    output logic [WIDTH-1:0]   mult_b,
    input  logic [2*WIDTH-1:0] mult_p,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [16:0]        vec_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic [2*WIDTH-1:0] fail_p
);
    localparam int              PW           = 2 * WIDTH;
    localparam logic [15:0]     SEED_DEFAULT = 16'hACE1;
    localparam logic [15:0]     LFSR_MASK    = 16'hB400;
    localparam logic [16:0]     EXH_TOTAL    = 17'(1) << PW;
    localparam logic [16:0]     RND_TOTAL    = 17'(NUM_VECTORS);
    localparam logic [7:0]      SETTLE_LAST  = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;
    localparam logic [WIDTH-1:0] OP_MAX      = '1;

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

    state_t        state, state_next;
    logic          mode_q;
    logic          first_fail_seen;
    logic [15:0]   lfsr;
    logic [7:0]    settle_cnt;

    logic          start_ok;
    logic          mismatch;
    logic          last_vec;
    logic [15:0]   seed_eff;
    logic [15:0]   lfsr_adv;
    logic [PW-1:0] golden;
    logic [16:0]   vec_count_inc;

    assign seed_eff      = (seed == 16'd0) ? SEED_DEFAULT : seed;
    assign lfsr_adv      = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'd0);
    assign golden        = PW'(mult_a) * PW'(mult_b);
    assign mismatch      = (mult_p != golden);
    assign vec_count_inc = vec_count + 17'd1;
    assign last_vec      = (vec_count_inc == (mode_q ? RND_TOTAL : EXH_TOTAL));
    // abort outranks start even when the sequencer is idle
    assign start_ok      = start && !abort && (state == S_IDLE || state == S_DONE);

    assign busy = (state == S_APPLY) || (state == S_WAIT) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort && state != S_IDLE) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start_ok) state_next = S_APPLY;
                S_APPLY:        state_next = (SETTLE_CYCLES > 0) ? S_WAIT : S_CHECK;
                S_WAIT:         if (settle_cnt == SETTLE_LAST) state_next = S_CHECK;
                S_CHECK:        state_next = last_vec ? S_DONE : S_APPLY;
                default:        state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q          <= 1'b0;
            lfsr            <= SEED_DEFAULT;
            settle_cnt      <= 8'd0;
            mult_a          <= '0;
            mult_b          <= '0;
            err_count       <= '0;
            vec_count       <= 17'd0;
            fail_a          <= '0;
            fail_b          <= '0;
            fail_p          <= '0;
            first_fail_seen <= 1'b0;
        end else if (start_ok) begin
            mode_q          <= mode;
            lfsr            <= seed_eff;
            mult_a          <= mode ? seed_eff[WIDTH-1:0] : '0;
            mult_b          <= mode ? seed_eff[PW-1:WIDTH] : '0;
            settle_cnt      <= 8'd0;
            err_count       <= '0;
            vec_count       <= 17'd0;
            fail_a          <= '0;
            fail_b          <= '0;
            fail_p          <= '0;
            first_fail_seen <= 1'b0;
        end else if (!abort) begin
            case (state)
                S_APPLY: settle_cnt <= 8'd0;
                S_WAIT:  settle_cnt <= settle_cnt + 8'd1;
                S_CHECK: begin
                    vec_count <= vec_count_inc;
                    if (mismatch) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        if (!first_fail_seen) begin
                            first_fail_seen <= 1'b1;
                            fail_a          <= mult_a;
                            fail_b          <= mult_b;
                            fail_p          <= mult_p;
                        end
                    end
                    // the last vector stays on the operand bus through DONE
                    if (!last_vec) begin
                        if (mode_q) begin
                            lfsr   <= lfsr_adv;
                            mult_a <= lfsr_adv[WIDTH-1:0];
                            mult_b <= lfsr_adv[PW-1:WIDTH];
                        end else begin
                            mult_b <= mult_b + 1'b1;
                            if (mult_b == OP_MAX) mult_a <= mult_a + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult_bist_ctrl.md
Name: mult_bist_ctrl

Overview:
Built-in self-test sequencer for one combinational multiplier candidate produced by the design-space exploration flow. Drives operand vectors into the multiplier, waits a programmable settle time, and compares the product against an internal golden A*B. Reports pass/fail, an error count and the first failing vector, which replaces the per-candidate scripted bench in on-chip or emulated evaluation runs.

Parameters:
WIDTH, 2, operand width of the multiplier under test; legal range 1..8; product is 2*WIDTH bits.
NUM_VECTORS, 20, number of vectors applied in pseudo-random mode; legal range 1..65535.
SETTLE_CYCLES, 1, idle cycles between applying operands and sampling the product; legal range 0..255.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
abort  in  1  synchronous abort; returns to IDLE without asserting done.
mode  in  1  sampled at start: 0 = exhaustive, 1 = pseudo-random.
seed  in  16  LFSR seed, sampled at start; 0 is replaced by 16'hACE1.
mult_a  out  WIDTH  registered operand A to the multiplier.
mult_b  out  WIDTH  registered operand B to the multiplier.
mult_p  in  2*WIDTH  product returned by the multiplier.
busy  out  1  high from the cycle after an accepted start until DONE or IDLE.
done  out  1  high in DONE; held until the next accepted start or reset.
pass  out  1  valid while done=1: 1 iff no mismatches occurred.
err_count  out  ERR_W  mismatch count, saturating at all-ones.
vec_count  out  17  number of vectors checked in the current or last run.
fail_a, fail_b  out  WIDTH  operands of the first mismatch.
fail_p  out  2*WIDTH  observed product of the first mismatch.

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs are 0, including mult_a/b and the fail_* registers. LFSR=16'hACE1.
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE + start: latch mode and seed, clear err_count, vec_count and fail_*, clear the first-fail flag, and drop done. Load the first vector and go to APPLY. busy=1 from the next cycle.
- Exhaustive order: B is the inner loop, A the outer loop: (0,0),(0,1)..(0,2^W-1),(1,0)..; the run covers 2^(2*WIDTH) vectors.
- Pseudo-random vectors:
  - 16-bit Galois LFSR, mask 16'hB400, shifted right.
  - A = lfsr[WIDTH-1:0], B = lfsr[2*WIDTH-1:WIDTH].
  - The first vector uses the loaded seed; the LFSR advances once per vector.
- APPLY: 1 cycle; mult_a/b show the current vector. Go to WAIT if SETTLE_CYCLES>0, else go to CHECK.
- WAIT: exactly SETTLE_CYCLES cycles, then CHECK.
- CHECK, 1 cycle:
  - Compare mult_p with zero-extended A*B, truncated to 2*WIDTH bits.
  - On a mismatch, increment err_count (saturating). If this is the first mismatch, capture fail_a/b/p.
  - vec_count increments.
  - If this was the last vector, go to DONE; otherwise advance the vector and go to APPLY.
- Cost per vector: 2+SETTLE_CYCLES cycles.
- DONE: done=1, busy=0, pass=(err_count==0). mult_a/b hold the last vector.
- abort has priority over every transition. In any non-IDLE state it forces IDLE with busy=0 and done=0. err_count and vec_count hold their partial values; pass=0.
- start while busy is ignored. start and abort in the same cycle: abort wins.
- mult_p is sampled only in CHECK; its value in other states is don't-care.
- Reset mid-run: immediate IDLE with all outputs cleared.

Test Plan:
- WIDTH=2, SETTLE_CYCLES=1, exhaustive, correct multiplier; pulse start -> 16 vectors, done at 48 cycles after start+1, vec_count=16, err_count=0, pass=1.
- Same setup, multiplier with P[0] stuck at 0 -> err_count=4 (A,B in {1,3}), pass=0, fail_a=1, fail_b=1, fail_p=0.
- WIDTH=2, mode=1, seed=0, NUM_VECTORS=20 -> first vector is A=1, B=0 (from 16'hACE1), vec_count=20, pass=1 with a correct multiplier; the vector sequence matches the reference LFSR model.
- WIDTH=8, exhaustive, mult_p tied to 0 -> 65025 mismatches, err_count saturates at 255, first fail A=1, B=1, P=0, vec_count=65536.
- Abort asserted during WAIT of vector 5 -> IDLE next cycle, busy=0, done=0, vec_count=5. Then start -> a full fresh run with counters cleared.
- Start pulsed while busy has no effect. rst_n low mid-run -> all outputs 0 immediately; after release, start gives a normal run.
